// File: rtl/ofmap_writeback_if.sv
// Bus interfaces for ofmap_writeback.
//   ofmap_acc_if : accumulator vector stream (valid/ready/data).
//                  master = accumulator backend, slave = writeback unit.
//   ofmap_ram_if : IA RAM write port (we/addr/wdata); the RAM never stalls.
//                  master = writeback unit, slave = IA RAM.
interface ofmap_acc_if #(
  parameter int LANES     = 8,
  parameter int ACC_WIDTH = 17
) ();
  logic                         valid;
  logic                         ready;
  logic [LANES*ACC_WIDTH-1:0]   data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

interface ofmap_ram_if #(
  parameter int LANES      = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 11
) ();
  logic                         we;
  logic [ADDR_WIDTH-1:0]        addr;
  logic [LANES*OUT_WIDTH-1:0]   wdata;

  modport master (output we, output addr, output wdata);
  modport slave  (input we, input addr, input wdata);
endinterface

// File: rtl/ofmap_writeback.sv
// ofmap_writeback: requantizes accumulated output-feature-map vectors and
// writes them as packed words into the input-activation RAM.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_start             one-cycle frame start (honoured only in IDLE)
//   i_base_addr         first RAM word address (latched on start)
//   i_num_words         vectors in the frame (latched on start)
//   i_shift, i_relu_en  requantization controls (latched on start)
//   acc                 accumulator vector stream (slave)
//   ram                 IA RAM write port (master)
//   o_busy              high whenever the FSM is not IDLE
//   o_done              one-cycle end-of-frame pulse
//   o_sat_count         lanes clipped in the current frame (saturating)
module ofmap_writeback #(
  parameter int LANES      = 8,
  parameter int ACC_WIDTH  = 17,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_num_words,
  input  logic [4:0]            i_shift,
  input  logic                  i_relu_en,
  ofmap_acc_if.slave            acc,
  ofmap_ram_if.master           ram,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_sat_count
);

  localparam int EXT_W = ACC_WIDTH + 1;
  localparam int CNT_W = $clog2(LANES + 1);
  localparam logic signed [EXT_W-1:0] U_MAX = EXT_W'((1 << OUT_WIDTH) - 1);
  localparam logic signed [EXT_W-1:0] S_MAX = EXT_W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] S_MIN = EXT_W'(-(1 << (OUT_WIDTH - 1)));
  localparam logic [ADDR_WIDTH:0]     K_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  // Round-half-up then arithmetic shift; one guard bit absorbs the rounding add.
  function automatic logic signed [EXT_W-1:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] v,
    input logic [4:0]                  sh
  );
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    ext = {v[ACC_WIDTH-1], v};
    rnd = '0;
    if (sh != 5'd0) rnd = {{(EXT_W-1){1'b0}}, 1'b1} << (sh - 5'd1);
    return (ext + rnd) >>> sh;
  endfunction

  // Returns {clipped, value}. ReLU zeroing of negatives is not a clip.
  function automatic logic [OUT_WIDTH:0] saturate(
    input logic signed [EXT_W-1:0] v,
    input logic                    relu
  );
    if (relu) begin
      if (v < 0)          return {1'b0, {OUT_WIDTH{1'b0}}};
      else if (v > U_MAX) return {1'b1, {OUT_WIDTH{1'b1}}};
      else                return {1'b0, v[OUT_WIDTH-1:0]};
    end else begin
      if (v > S_MAX)      return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (v < S_MIN) return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                return {1'b0, v[OUT_WIDTH-1:0]};
    end
  endfunction

  state_t                      r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]       r_base;
  logic [ADDR_WIDTH:0]         r_num;
  logic [ADDR_WIDTH:0]         r_k;
  logic [4:0]                  r_shift;
  logic                        r_relu;
  logic [15:0]                 r_sat;
  logic                        r_vld_p1;
  logic [ADDR_WIDTH-1:0]       r_addr_p1;
  logic [LANES*OUT_WIDTH-1:0]  r_wdata_p1;

  logic                        w_ready;
  logic                        w_hs;
  logic                        w_start_ok;
  logic [OUT_WIDTH:0]          w_sq;
  logic [LANES*OUT_WIDTH-1:0]  w_qdata;
  logic [CNT_W-1:0]            w_nclip;
  logic [16:0]                 w_sat_sum;

  // Ready depends only on state and k so it never waits on acc.valid.
  assign w_ready    = (r_state == S_RUN) && (r_k < r_num);
  assign w_hs       = acc.valid && w_ready;
  assign w_start_ok = (r_state == S_IDLE) && i_start;
  assign acc.ready  = w_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    o_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = (i_num_words == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_hs && ((r_k + K_ONE) == r_num)) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_DONE;
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // p0: quantize all lanes of the presented vector
  always_comb begin
    w_sq    = '0;
    w_qdata = '0;
    w_nclip = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sq = saturate(round_shift(acc.data[l*ACC_WIDTH +: ACC_WIDTH], r_shift), r_relu);
      w_qdata[l*OUT_WIDTH +: OUT_WIDTH] = w_sq[OUT_WIDTH-1:0];
      w_nclip = w_nclip + CNT_W'(w_sq[OUT_WIDTH]);
    end
  end

  assign w_sat_sum = {1'b0, r_sat} + 17'(w_nclip);

  // p1: registered RAM write, one cycle after the handshake
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_base     <= '0;
      r_num      <= '0;
      r_k        <= '0;
      r_shift    <= '0;
      r_relu     <= 1'b0;
      r_sat      <= '0;
      r_vld_p1   <= 1'b0;
      r_addr_p1  <= '0;
      r_wdata_p1 <= '0;
    end else begin
      r_vld_p1 <= w_hs;
      if (w_start_ok) begin
        r_base  <= i_base_addr;
        r_num   <= i_num_words;
        r_shift <= i_shift;
        r_relu  <= i_relu_en;
        r_k     <= '0;
        r_sat   <= '0;
      end
      if (w_hs) begin
        r_wdata_p1 <= w_qdata;
        r_addr_p1  <= r_base + r_k[ADDR_WIDTH-1:0];
        r_k        <= r_k + K_ONE;
        r_sat      <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
      end
    end
  end

  assign ram.we      = r_vld_p1;
  assign ram.addr    = r_addr_p1;
  assign ram.wdata   = r_wdata_p1;
  assign o_sat_count = r_sat;

endmodule

// File: doc/ofmap_writeback.md
# ofmap_writeback

Writeback unit that closes the activation loop of the accelerator: it takes accumulated output-feature-map vectors from the backend accumulator, requantizes them, and writes them as packed words into the input-activation RAM for the next layer to read. It sits between the backend accumulator output and the IA RAM write port. The control system configures and starts it once per output frame.

## Interface
- LANES, 8, output channels per vector; lane 0 occupies the LSBs.
- ACC_WIDTH, 17, signed accumulator width per lane.
- OUT_WIDTH, 8, quantized activation width per lane.
- ADDR_WIDTH, 11, IA RAM word address width.
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE and ignored otherwise.
- base_addr  in  ADDR_WIDTH  first write address; latched on start.
- num_words  in  ADDR_WIDTH+1  vectors in the frame; latched on start.
- shift  in  5  right-shift amount; latched on start.
- relu_en  in  1  1 selects unsigned ReLU output, 0 selects signed output; latched on start.
- acc_valid  in  1  accumulator vector valid.
- acc_ready  out  1  vector accepted when acc_valid && acc_ready.
- acc_data  in  LANES*ACC_WIDTH  signed lanes.
- ram_we  out  1  IA RAM write strobe. The RAM always accepts a write.
- ram_addr  out  ADDR_WIDTH  write address.
- ram_wdata  out  LANES*OUT_WIDTH  packed quantized lanes.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at the end of the frame.
- sat_count  out  16  number of lanes clipped in the current frame.

## Operation
- FSM states are IDLE, RUN, FLUSH and DONE.
- IDLE:
  - On start with num_words = 0, go to DONE.
  - On start with num_words > 0, go to RUN.
  - Start also clears sat_count and the accepted-vector counter k.
- RUN:
  - acc_ready = 1 while k < num_words.
  - Each handshake quantizes all lanes, registers the packed word with address base_addr + k, and increments k.
  - The handshake that accepts vector num_words-1 moves the FSM to FLUSH.
- FLUSH: the final write is presented. Go to DONE next.
- DONE: done = 1. Go to IDLE next.
- Per-lane arithmetic, computed at ACC_WIDTH+1 bits signed:
  - If shift > 0, add 2^(shift-1) for rounding.
  - Arithmetic right shift by shift, so results floor.
  - With relu_en = 1: negative results become 0 (not counted as saturation), and values above 2^OUT_WIDTH-1 clip to that maximum.
  - With relu_en = 0: results clip to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] in two's complement.
- sat_count increments by the number of lanes clipped at each handshake. It saturates at 0xFFFF and holds its value after done until the next start.
- Addresses wrap modulo 2^ADDR_WIDTH.
- Reset mid-frame:
  - The next cycle is IDLE with all outputs 0.
  - No further writes occur.
  - Words already written stay in the RAM.

## Timing
- Reset values: acc_ready, ram_we, ram_addr, ram_wdata, busy, done and sat_count are all 0.
- Latency: a handshake in cycle N gives ram_we = 1 with its address and data in cycle N+1.
- ram_we is low in every cycle not preceded by a handshake.
- Throughput is one vector per cycle. acc_valid gaps create ram_we gaps.
- With the last handshake in cycle N:
  - N+1: FLUSH, last write.
  - N+2: done = 1.
  - N+3: IDLE; a start pulse is accepted from this cycle.
- acc_ready is combinational from the state and k only, never from acc_valid. It is low in IDLE, FLUSH and DONE.
- For num_words = 0 with start in cycle N: done = 1 in N+1, and no ram_we occurs.
- busy is high from the cycle after start through the done cycle.

## Test plan
- Reset: hold reset = 0 for 3 cycles with random inputs -> every output 0 and acc_ready never asserted.
- Basic frame:
  - Stimulus: base_addr=5, num_words=3, shift=2, relu_en=1; lane-0 values 10, -6, 1100.
  - Writes: addresses 5, 6, 7 with lane 0 = 3, 0, 255.
  - sat_count=1; done exactly 2 cycles after the third handshake.
- Signed clipping: shift=0, relu_en=0, lanes 1000, -1000, 127, -128 -> bytes 0x7F, 0x80, 0x7F, 0x80; sat_count=2.
- Backpressure:
  - Stimulus: num_words=4, acc_valid toggling every cycle, then held high for 3 more cycles.
  - Required: exactly 4 writes, each one cycle after its handshake; acc_ready low once k=4.
- Wrap: base_addr=2046, num_words=4 -> ram_addr sequence 2046, 2047, 0, 1.
- Reset and zero-length:
  - reset=0 after the 2nd of 5 handshakes -> exactly 2 writes, then IDLE.
  - num_words=0 -> done one cycle after start, no writes.
  - start during RUN -> ignored, frame unaffected.
